// File: rtl/ccd_timing_mc.sv
// Multi-channel linear-CCD timing generator with shared-CS/SCLK ADC readout and pixel publication.
// Optional test-pattern data path is enabled by defining CCD_TEST_PATTERN_EN (adds input test_pat).
module ccd_timing_mc #(
    parameter int NUM_PIX   = 2048,
    parameter int DUMMY_PIX = 32,
    parameter int ADC_BITS  = 16,
    parameter int NUM_CH    = 2,
    parameter int CLK_DIV   = 4,
    parameter int SH_CYCLES = 80
) (
    input  logic                         clk_80M,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         cal_mode,
    input  logic [23:0]                  line_period,
`ifdef CCD_TEST_PATTERN_EN
    input  logic                         test_pat,
`endif
    output logic                         ccd_p1,
    output logic                         ccd_p2,
    output logic                         ccd_sh,
    output logic                         ccd_rs,
    output logic                         ccd_cp,
    output logic                         adc_cs,
    output logic                         adc_sclk,
    input  logic [NUM_CH-1:0]            adc_sdo,
    output logic                         pix_clk,
    output logic                         pix_valid,
    output logic                         pix_dark,
    output logic [15:0]                  pix_index,
    output logic [NUM_CH*ADC_BITS-1:0]   pix_data,
    output logic                         line_start,
    output logic                         line_done,
    output logic                         busy
);

    localparam int SLOTS = NUM_PIX + DUMMY_PIX;
    localparam int UNITS = 2 * ADC_BITS + 4;
    localparam int SW    = $clog2(SLOTS + 1);
    localparam int CW    = $clog2(SH_CYCLES + 1);
    localparam int UW    = $clog2(UNITS);
    localparam int DW    = $clog2(CLK_DIV + 1);
    localparam int DATW  = NUM_CH * ADC_BITS;

    localparam logic [UW-1:0] U_CP       = UW'(1);
    localparam logic [UW-1:0] U_CSU      = UW'(2);
    localparam logic [UW-1:0] U_SH_FIRST = UW'(3);
    localparam logic [UW-1:0] U_SH_LAST  = UW'(2 * ADC_BITS + 2);
    localparam logic [UW-1:0] U_PUB      = UW'(2 * ADC_BITS + 3);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SH_LAST    = CW'(SH_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOTS - 1);
    localparam logic [SW-1:0] SLOT_DUM   = SW'(DUMMY_PIX);
    localparam logic [23:0]   TIMER_MAX  = 24'hFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_SH_PULSE, S_SH_HOLD, S_PIXEL, S_LINE_END, S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   sh_cnt_q, sh_cnt_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [UW-1:0]   unit_q, unit_d;
    logic [DW-1:0]   div_q, div_d;
    logic [23:0]     timer_q, timer_d;
    logic [23:0]     period_q, period_d;
    logic            cal_q, cal_d;
    logic [15:0]     pub_cnt_q, pub_cnt_d;
    logic [DATW-1:0] shreg_q, shreg_d;
    logic [DATW-1:0] data_q, data_d;
    logic [15:0]     index_q, index_d;
    logic            dark_q, dark_d;

    logic            tp;
    logic            is_dummy, publish, sample_edge, start_line, go_idle;
    logic            reach_now, reach_wait;
    logic [24:0]     timer_nx;
    logic [DATW-1:0] pub_word;

`ifdef CCD_TEST_PATTERN_EN
    assign tp = test_pat;
`else
    assign tp = 1'b0;
`endif

    assign is_dummy    = slot_q < SLOT_DUM;
    assign publish     = cal_q | ~is_dummy;
    assign sample_edge = (unit_q >= U_SH_FIRST) && (unit_q < U_SH_LAST) && unit_q[0];
    // The sh-to-sh distance counts the first SH_PULSE cycle as 0, so the exit test looks one cycle ahead.
    assign timer_nx    = {1'b0, timer_q} + 25'd1;
    assign reach_now   = timer_nx >= {1'b0, line_period};
    assign reach_wait  = timer_nx >= {1'b0, period_q};

    always_comb begin
        pub_word = shreg_q;
        if (tp) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pub_word[c*ADC_BITS +: ADC_BITS] = pub_cnt_q[ADC_BITS-1:0] ^ ADC_BITS'(c);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        slot_d     = slot_q;
        unit_d     = unit_q;
        div_d      = div_q;
        timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + 24'd1;
        period_d   = period_q;
        cal_d      = cal_q;
        pub_cnt_d  = pub_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        index_d    = index_q;
        dark_d     = dark_q;
        start_line = 1'b0;
        go_idle    = 1'b0;

        case (state_q)
            S_IDLE: start_line = en;
            S_SH_PULSE: begin
                if (sh_cnt_q == SH_LAST) begin
                    state_d  = S_SH_HOLD;
                    sh_cnt_d = '0;
                end else begin
                    sh_cnt_d = sh_cnt_q + CW'(1);
                end
            end
            S_SH_HOLD: begin
                if (sh_cnt_q == SH_LAST) begin
                    state_d = S_PIXEL;
                    slot_d  = '0;
                    unit_d  = '0;
                    div_d   = '0;
                end else begin
                    sh_cnt_d = sh_cnt_q + CW'(1);
                end
            end
            S_PIXEL: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sample_edge) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            shreg_d[c*ADC_BITS +: ADC_BITS] =
                                {shreg_q[c*ADC_BITS +: ADC_BITS-1], adc_sdo[c]};
                        end
                    end
                    // Words are always latched; only published ones advance the index.
                    if (unit_q == U_SH_LAST) begin
                        data_d = pub_word;
                        dark_d = is_dummy & cal_q;
                        if (publish) begin
                            index_d   = pub_cnt_q;
                            pub_cnt_d = pub_cnt_q + 16'd1;
                        end
                    end
                    if (unit_q == U_PUB) begin
                        unit_d = '0;
                        if (slot_q == SLOT_LAST) begin
                            state_d = S_LINE_END;
                        end else begin
                            slot_d = slot_q + SW'(1);
                        end
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_LINE_END: begin
                period_d = line_period;
                if (!en) begin
                    go_idle = 1'b1;
                end else if (reach_now) begin
                    start_line = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    go_idle = 1'b1;
                end else if (reach_wait) begin
                    start_line = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d = S_IDLE;
            data_d  = '0;
            index_d = '0;
            dark_d  = 1'b0;
        end
        if (start_line) begin
            state_d   = S_SH_PULSE;
            sh_cnt_d  = '0;
            timer_d   = '0;
            cal_d     = cal_mode;
            pub_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sh_cnt_q  <= '0;
            slot_q    <= '0;
            unit_q    <= '0;
            div_q     <= '0;
            timer_q   <= '0;
            period_q  <= '0;
            cal_q     <= 1'b0;
            pub_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            index_q   <= '0;
            dark_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_cnt_q  <= sh_cnt_d;
            slot_q    <= slot_d;
            unit_q    <= unit_d;
            div_q     <= div_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            cal_q     <= cal_d;
            pub_cnt_q <= pub_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            index_q   <= index_d;
            dark_q    <= dark_d;
        end
    end

    logic in_pixel;
    assign in_pixel   = (state_q == S_PIXEL);
    assign ccd_p1     = in_pixel ? ~slot_q[0] : 1'b1;
    assign ccd_p2     = in_pixel & slot_q[0];
    assign ccd_sh     = (state_q == S_SH_PULSE);
    assign ccd_rs     = in_pixel && (unit_q == '0);
    assign ccd_cp     = in_pixel && (unit_q == U_CP);
    assign adc_cs     = ~(in_pixel && (unit_q >= U_CSU) && (unit_q <= U_SH_LAST));
    // SHIFT starts on an odd unit, so even units inside it are the SCLK high halves.
    assign adc_sclk   = in_pixel && (unit_q >= U_SH_FIRST) && (unit_q <= U_SH_LAST) && ~unit_q[0];
    assign pix_clk    = in_pixel && (unit_q == U_PUB) && publish;
    assign pix_valid  = pix_clk && (div_q == '0);
    assign pix_dark   = dark_q;
    assign pix_index  = index_q;
    assign pix_data   = data_q;
    assign line_start = ccd_sh && (sh_cnt_q == '0);
    assign line_done  = (state_q == S_LINE_END);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ccd_timing_mc.sv
// Scoreboard bench for ccd_timing_mc: ADC serial model pushes expected words, pixel strobes pop them.
module tb_ccd_timing_mc;

    localparam int NP   = 8;
    localparam int DP   = 2;
    localparam int AB   = 16;
    localparam int NC   = 2;
    localparam int CD   = 2;
    localparam int SHC  = 4;
    localparam int TPIX = (2 * AB + 4) * CD;
    localparam int NAT  = 2 * SHC + (NP + DP) * TPIX + 1;
    localparam logic [12:0] REST = 13'b1000010000000;

    logic          clk_80M = 1'b0;
    logic          rst_n, en, cal_mode;
    logic [23:0]   line_period;
    logic          tp_drive;
    logic          ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, adc_cs, adc_sclk;
    logic [NC-1:0] adc_sdo = '0;
    logic          pix_clk, pix_valid, pix_dark, line_start, line_done, busy;
    logic [15:0]   pix_index;
    logic [NC*AB-1:0] pix_data;

    always #5 clk_80M = ~clk_80M;

    ccd_timing_mc #(
        .NUM_PIX(NP), .DUMMY_PIX(DP), .ADC_BITS(AB), .NUM_CH(NC), .CLK_DIV(CD), .SH_CYCLES(SHC)
    ) dut (
        .clk_80M(clk_80M), .rst_n(rst_n), .en(en), .cal_mode(cal_mode), .line_period(line_period),
`ifdef CCD_TEST_PATTERN_EN
        .test_pat(tp_drive),
`endif
        .ccd_p1(ccd_p1), .ccd_p2(ccd_p2), .ccd_sh(ccd_sh), .ccd_rs(ccd_rs), .ccd_cp(ccd_cp),
        .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_sdo(adc_sdo),
        .pix_clk(pix_clk), .pix_valid(pix_valid), .pix_dark(pix_dark), .pix_index(pix_index),
        .pix_data(pix_data), .line_start(line_start), .line_done(line_done), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] idx;
        logic        dark;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wait_evt(input string tag, input int sel, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk_80M);
            case (sel)
                0:       hit = line_start;
                1:       hit = line_done;
                default: hit = adc_sclk;
            endcase
        end
        if (!hit) chk({"timeout_", tag}, 0, 1);
    endtask

    int cyc = 0;
    always @(posedge clk_80M) cyc <= cyc + 1;

    // Monitor / ADC model / scoreboard state
    int          exp_gap = 0;
    bit          vary = 1'b0;
    bit          line_cal = 1'b0, tp_line = 1'b0;
    int          pub_idx = 0, slot_cnt = 0, npub = 0, npclk = 0, n_ls = 0;
    int          rise_cyc = 0, done_cyc = 0, bcnt = 16;
    bit          have_rise = 1'b0, want_first = 1'b0;
    logic        prev_sh = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0, prev_pv = 1'b0;
    logic [15:0] w0 = '0, w1 = '0;

    always @(negedge clk_80M) begin : monitor
        exp_t e;
        int   n_exp;
        if (line_start) begin
            line_cal = cal_mode;
            tp_line  = tp_drive;
            pub_idx  = 0;
            slot_cnt = 0;
            npub     = 0;
            npclk    = 0;
            n_ls++;
        end
        if (ccd_sh && !prev_sh) begin
            chk("ls_on_sh", line_start, 1);
            if (have_rise && exp_gap != 0) chk("sh_gap", cyc - rise_cyc, exp_gap);
            if (have_rise && exp_gap > NAT) chk("wait_len", cyc - done_cyc, exp_gap - (NAT - 1));
            rise_cyc   = cyc;
            have_rise  = 1'b1;
            want_first = 1'b1;
        end
        if (!adc_cs && prev_cs) begin
            w0   = vary ? 16'($urandom_range(0, 65535)) : 16'hA5C3;
            w1   = vary ? 16'($urandom_range(0, 65535)) : 16'h1234;
            bcnt = 0;
            if (slot_cnt >= DP || line_cal) begin
                e.idx  = 16'(pub_idx);
                e.dark = (slot_cnt < DP);
                e.data = tp_line ? {e.idx ^ 16'd1, e.idx} : {w1, w0};
                q.push_back(e);
                pub_idx++;
            end
            slot_cnt++;
        end
        if (!adc_sclk && prev_sclk) bcnt++;
        adc_sdo = (bcnt < 16) ? {w1[15-bcnt], w0[15-bcnt]} : 2'b00;
        if (pix_clk) npclk++;
        if (pix_valid) begin
            chk("pv_width", prev_pv, 0);
            chk("pclk_at_pv", pix_clk, 1);
            if (want_first) begin
                chk("first_pv_lat", cyc - rise_cyc,
                    2 * SHC + (line_cal ? 0 : DP) * TPIX + TPIX - CD);
                want_first = 1'b0;
            end
            if (q.size() == 0) begin
                chk("pv_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("pix_index", pix_index, e.idx);
                chk("pix_data", pix_data, e.data);
                chk("pix_dark", pix_dark, e.dark);
                if (tp_line && e.idx == 16'd5) chk("tp_pix5", pix_data, 32'h0004_0005);
            end
            npub++;
        end
        if (line_done) begin
            n_exp = line_cal ? (NP + DP) : NP;
            chk("npub", npub, n_exp);
            chk("npclk", npclk, n_exp * CD);
            chk("q_empty", q.size(), 0);
            done_cyc = cyc;
        end
        prev_sh   = ccd_sh;
        prev_cs   = adc_cs;
        prev_sclk = adc_sclk;
        prev_pv   = pix_valid;
    end

    initial begin
        int ls_snap;
        rst_n = 1'b0; en = 1'b0; cal_mode = 1'b0; line_period = 24'd0; tp_drive = 1'b0;
        repeat (3) @(negedge clk_80M);
        chk("rst_ctl", {ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, adc_cs, adc_sclk, pix_clk,
                        pix_valid, pix_dark, line_start, line_done, busy}, REST);
        chk("rst_idx", pix_index, 0);
        chk("rst_data", pix_data, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_80M);
        chk("idle_busy", busy, 0);

        // Normal mode, constant ADC words, free-running line period
        exp_gap = NAT;
        en = 1'b1;
        repeat (3) wait_evt("t1_done", 1, 1500);

        // Calibration mode with random ADC words
        cal_mode = 1'b1;
        vary = 1'b1;
        repeat (2) wait_evt("t2_done", 1, 1500);

        // Programmed line period longer than the natural line
        wait_evt("t3_ls", 0, 1500);
        @(negedge clk_80M);
        line_period = 24'd1000;
        exp_gap = 1000;
        repeat (2) wait_evt("t3_ls2", 0, 1500);
        @(negedge clk_80M);
        line_period = 24'd0;
        exp_gap = NAT;

        // en dropped during slot 3 finishes the line, then rests in IDLE
        wait_evt("t4_ls", 0, 1500);
        @(negedge clk_80M);
        cal_mode = 1'b0;
        repeat (2 * SHC + 3 * TPIX + 20) @(negedge clk_80M);
        en = 1'b0;
        wait_evt("t4_done", 1, 1500);
        repeat (2) @(negedge clk_80M);
        chk("idle_ctl", {ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, adc_cs, adc_sclk, pix_clk,
                         pix_valid, pix_dark, line_start, line_done, busy}, REST);
        chk("idle_idx", pix_index, 0);
        chk("idle_data", pix_data, 0);
        ls_snap = n_ls;
        repeat (40) @(negedge clk_80M);
        chk("idle_stay", n_ls, ls_snap);

        // Asynchronous reset in the SHIFT phase
        exp_gap = 0;
        en = 1'b1;
        wait_evt("t5_sclk", 2, 400);
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", {ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, adc_cs, adc_sclk, pix_clk,
                         pix_valid, pix_dark, line_start, line_done, busy}, REST);
        chk("arst_data", pix_data, 0);
        q.delete();
        @(negedge clk_80M);
        rst_n = 1'b1;
        @(posedge clk_80M);
        #1;
        chk("restart_sh", {ccd_sh, line_start, busy}, 3'b111);
        wait_evt("t5_done", 1, 1500);

`ifdef CCD_TEST_PATTERN_EN
        tp_drive = 1'b1;
`endif
        wait_evt("t6_ls", 0, 100);
        @(negedge clk_80M);
        en = 1'b0;
        wait_evt("t6_done", 1, 1500);
        repeat (3) @(negedge clk_80M);
        chk("end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
